rgmii_tx_framer: RTL and testbench

Synthesizable, parametrised successor to the pcap-driven RGMII TX stimulus. It takes a byte stream (valid/ready/last) and emits a complete Ethernet frame on an SDR MII/GMII-style interface: IFG, preamble/SFD, payload, zero-padding to the minimum size, and an optional FCS. Frame format is selectable per frame between nibble mode (10/100) and byte mode (giga). The block sits in front of the RGMII DDR output stage (ODDR/clock-skew logic external). It replaces the BFM in TSU benches and serves as the TX path of the switch port.

---
 rtl/tsn_eth_pkg.sv | 24 ++
 rtl/rgmii_tx_framer_if.sv | 12 +
 rtl/eth_crc32_d8.sv | 24 ++
 rtl/rgmii_tx_framer.sv | 212 +++++++++++++++++++++
 tb/tb_rgmii_tx_framer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tsn_eth_pkg.sv
// Shared Ethernet framing types and constants for the TSN port datapath.
// No logic; types and constants only.
// Not applicable (no handshake).
package tsn_eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam int          MIN_FRAME_NOFCS = 60;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE     = 32'hC704DD7B;
  // 0x04C11DB7 bit-reversed, for the LSB-first shift form
  localparam logic [31:0] CRC_POLY_REFL   = 32'hEDB88320;

endpackage

// File: rtl/rgmii_tx_framer_if.sv
// Byte-stream handshake into the TX framer (valid/ready/last).
// No logic; wiring only.
// Byte moves on s_valid & s_ready; source holds data while s_ready is low.
interface rgmii_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input  s_ready);
  modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

// File: rtl/eth_crc32_d8.sv
// Next-state of the IEEE 802.3 reflected CRC32 for one byte, LSB first.
// Purely combinational, zero cycles.
// No handshake; caller decides when to register the result.
module eth_crc32_d8
  import tsn_eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Shift the eight data bits through the reflected polynomial, bit 0 first
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY_REFL;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/rgmii_tx_framer.sv
// Frames a byte stream into preamble/SFD/data/pad/FCS/IFG on an SDR MII/GMII bus.
// Accepted byte appears on txd one clk after the handshake; outputs registered.
// s_ready only at slot starts in DATA; a missing byte aborts the frame with tx_er.
module rgmii_tx_framer
  import tsn_eth_pkg::*;
#(
  parameter int IFG_BYTES      = 12,
  parameter int PREAMBLE_BYTES = 7,
  parameter int ADD_FCS        = 1,
  parameter int PAD_EN         = 1,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 giga_mode,
  rgmii_tx_framer_if.slave     s,
  output logic [7:0]           txd,
  output logic                 tx_en,
  output logic                 tx_er,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     underrun_cnt
);

  state_t            state, state_n;
  logic              phase, phase_n;       // 1 = high-nibble clk of a nibble slot
  logic              mode_giga, mode_n;    // mode latched at frame start
  logic              drain, drain_n;       // discarding the rest of an aborted frame
  logic              aborted, aborted_n;
  logic              last_rdy;
  logic [15:0]       cnt, cnt_n, cnt_inc;  // preamble / data / FCS / IFG slot counter
  logic [31:0]       crc, crc_n, crc_next, fcs_word;
  logic [7:0]        crc_din;
  logic [3:0]        hi_nib, hi_nib_n;
  logic [7:0]        txd_n;
  logic              tx_en_n, tx_er_n;
  logic [CNT_W-1:0]  frame_cnt_n, underrun_cnt_n;
  logic              slot_load, slot_nib, slot_en, slot_er;
  logic [7:0]        slot_byte;
  logic              data_rdy, drain_rdy, rdy;

  // Data bytes saturate so very long frames never look short to the pad check
  assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign fcs_word = ~crc;
  assign crc_din  = (state == ST_DATA) ? s.s_data : 8'h00;

  // Ready depends on registers only; the drain path alternates in nibble mode
  assign data_rdy  = (state == ST_DATA) && !phase;
  assign drain_rdy = drain && (state == ST_IDLE || state == ST_IFG) && !(last_rdy && !mode_giga);
  assign rdy       = data_rdy | drain_rdy;
  assign s.s_ready = rdy;
  assign busy      = (state != ST_IDLE);

  eth_crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (crc_din),
    .crc_out (crc_next)
  );

  // Slot decisions at phase 0: choose the next byte, advance the frame state
  always_comb begin
    state_n        = state;
    phase_n        = phase;
    mode_n         = mode_giga;
    drain_n        = drain;
    aborted_n      = aborted;
    cnt_n          = cnt;
    crc_n          = crc;
    hi_nib_n       = hi_nib;
    txd_n          = txd;
    tx_en_n        = tx_en;
    tx_er_n        = tx_er;
    frame_cnt_n    = frame_cnt;
    underrun_cnt_n = underrun_cnt;
    slot_load      = 1'b0;
    slot_nib       = !mode_giga;
    slot_en        = 1'b0;
    slot_er        = 1'b0;
    slot_byte      = 8'h00;

    if (!phase) begin
      slot_load = 1'b1;
      case (state)
        ST_IDLE: begin
          slot_nib = 1'b0;
          if (s.s_valid && !drain) begin
            mode_n    = giga_mode;
            slot_nib  = !giga_mode;
            slot_en   = 1'b1;
            slot_byte = PREAMBLE_BYTE;
            aborted_n = 1'b0;
            cnt_n     = 16'd1;
            state_n   = (PREAMBLE_BYTES == 1) ? ST_SFD : ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          slot_en   = 1'b1;
          slot_byte = PREAMBLE_BYTE;
          cnt_n     = cnt_inc;
          if (cnt_inc == 16'(PREAMBLE_BYTES)) state_n = ST_SFD;
        end
        ST_SFD: begin
          slot_en   = 1'b1;
          slot_byte = SFD_BYTE;
          crc_n     = CRC_INIT;
          cnt_n     = 16'd0;
          state_n   = ST_DATA;
        end
        ST_DATA: begin
          slot_en = 1'b1;
          if (s.s_valid) begin
            slot_byte = s.s_data;
            crc_n     = crc_next;
            cnt_n     = cnt_inc;
            if (s.s_last) begin
              if ((PAD_EN != 0) && (cnt_inc < 16'(MIN_FRAME_NOFCS))) begin
                state_n = ST_PAD;
              end else begin
                cnt_n   = 16'd0;
                state_n = (ADD_FCS != 0) ? ST_FCS : ST_IFG;
              end
            end
          end else begin
            // Source ran dry mid-frame: one error slot, then abandon the frame
            slot_er        = 1'b1;
            underrun_cnt_n = underrun_cnt + 1'b1;
            aborted_n      = 1'b1;
            drain_n        = 1'b1;
            cnt_n          = 16'd0;
            state_n        = ST_IFG;
          end
        end
        ST_PAD: begin
          slot_en = 1'b1;
          crc_n   = crc_next;
          cnt_n   = cnt_inc;
          if (cnt_inc >= 16'(MIN_FRAME_NOFCS)) begin
            cnt_n   = 16'd0;
            state_n = (ADD_FCS != 0) ? ST_FCS : ST_IFG;
          end
        end
        ST_FCS: begin
          slot_en   = 1'b1;
          slot_byte = fcs_word[{cnt[1:0], 3'b000} +: 8];
          cnt_n     = cnt_inc;
          if (cnt[1:0] == 2'd3) begin
            cnt_n   = 16'd0;
            state_n = ST_IFG;
          end
        end
        ST_IFG: begin
          cnt_n = cnt_inc;
          if (cnt_inc == 16'(IFG_BYTES)) begin
            cnt_n   = 16'd0;
            state_n = ST_IDLE;
            if (!aborted) frame_cnt_n = frame_cnt + 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    if (drain_rdy && s.s_valid && s.s_last) drain_n = 1'b0;

    if (slot_load) begin
      txd_n    = slot_nib ? {4'h0, slot_byte[3:0]} : slot_byte;
      hi_nib_n = slot_byte[7:4];
      tx_en_n  = slot_en;
      tx_er_n  = slot_er;
      phase_n  = slot_nib;
    end else begin
      txd_n    = {4'h0, hi_nib};
      phase_n  = 1'b0;
    end
  end

  // State and registered outputs; reset drops the bus immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      phase        <= 1'b0;
      mode_giga    <= 1'b0;
      drain        <= 1'b0;
      aborted      <= 1'b0;
      last_rdy     <= 1'b0;
      cnt          <= 16'd0;
      crc          <= CRC_INIT;
      hi_nib       <= 4'h0;
      txd          <= 8'h00;
      tx_en        <= 1'b0;
      tx_er        <= 1'b0;
      frame_cnt    <= '0;
      underrun_cnt <= '0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      mode_giga    <= mode_n;
      drain        <= drain_n;
      aborted      <= aborted_n;
      last_rdy     <= rdy;
      cnt          <= cnt_n;
      crc          <= crc_n;
      hi_nib       <= hi_nib_n;
      txd          <= txd_n;
      tx_en        <= tx_en_n;
      tx_er        <= tx_er_n;
      frame_cnt    <= frame_cnt_n;
      underrun_cnt <= underrun_cnt_n;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Directed bench for rgmii_tx_framer: default DUT plus a no-pad/no-FCS DUT.
// Frames are captured from tx_en/txd and checked against a local CRC model.
// Sender honours s_ready; every wait is bounded.
module tb_rgmii_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        giga_mode;
  logic        sel;
  logic [7:0]  drv_data;
  logic        drv_valid, drv_last;
  logic        abort;

  logic [7:0]  a_txd, b_txd;
  logic        a_tx_en, a_tx_er, a_busy, b_tx_en, b_tx_er, b_busy;
  logic [15:0] a_frame_cnt, a_underrun_cnt, b_frame_cnt, b_underrun_cnt;

  rgmii_tx_framer_if ifa ();
  rgmii_tx_framer_if ifb ();

  assign ifa.s_data  = drv_data;
  assign ifa.s_valid = drv_valid & ~sel;
  assign ifa.s_last  = drv_last;
  assign ifb.s_data  = drv_data;
  assign ifb.s_valid = drv_valid & sel;
  assign ifb.s_last  = drv_last;

  rgmii_tx_framer dut_a (
    .clk(clk), .rst_n(rst_n), .giga_mode(giga_mode), .s(ifa),
    .txd(a_txd), .tx_en(a_tx_en), .tx_er(a_tx_er), .busy(a_busy),
    .frame_cnt(a_frame_cnt), .underrun_cnt(a_underrun_cnt)
  );

  rgmii_tx_framer #(.ADD_FCS(0), .PAD_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .giga_mode(giga_mode), .s(ifb),
    .txd(b_txd), .tx_en(b_tx_en), .tx_er(b_tx_er), .busy(b_busy),
    .frame_cnt(b_frame_cnt), .underrun_cnt(b_underrun_cnt)
  );

  always #5 clk = ~clk;

  // Selected-DUT view
  logic [7:0] m_txd;
  logic       m_en, m_er, m_rdy, m_busy;
  assign m_txd  = sel ? b_txd   : a_txd;
  assign m_en   = sel ? b_tx_en : a_tx_en;
  assign m_er   = sel ? b_tx_er : a_tx_er;
  assign m_rdy  = sel ? ifb.s_ready : ifa.s_ready;
  assign m_busy = sel ? b_busy  : a_busy;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: rebuild bytes from the bus and collect timing statistics
  logic       mon_clr;
  logic       mon_giga;
  logic [7:0] cap[$];
  int         en_clks, er_clks, rdy_viol, hi_viol, idle_run, last_gap;
  logic       half, prev_en, prev_rdy, seen;
  logic [3:0] lo;

  always @(negedge clk) begin
    if (mon_clr) begin
      cap.delete();
      en_clks = 0; er_clks = 0; rdy_viol = 0; hi_viol = 0;
      idle_run = 0; last_gap = -1;
      half = 1'b0; prev_en = 1'b0; prev_rdy = 1'b0; seen = 1'b0; lo = 4'h0;
    end else begin
      if (m_en) begin
        en_clks++;
        if (m_er) er_clks++;
        if (mon_giga) cap.push_back(m_txd);
        else begin
          if (m_txd[7:4] != 4'h0) hi_viol++;
          if (!half) begin lo = m_txd[3:0]; half = 1'b1; end
          else begin cap.push_back({m_txd[3:0], lo}); half = 1'b0; end
        end
        if (!prev_en && seen) last_gap = idle_run;
        seen = 1'b1;
      end else begin
        idle_run = prev_en ? 1 : idle_run + 1;
      end
      if (m_rdy && prev_rdy && !mon_giga) rdy_viol++;
      prev_en  = m_en;
      prev_rdy = m_rdy;
    end
  end

  logic [7:0] pay [0:127];

  function automatic logic [7:0] capb(input int k);
    return (k < cap.size()) ? cap[k] : 8'hxx;
  endfunction

  // MSB-first register fed LSB-first bits: the bit-reverse of the reflected form
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[31] ^ d[b];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  function automatic logic [31:0] fcs_model(input int n_data, input int n_total);
    logic [31:0] c, rev;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_total; i++) c = crc_upd(c, (i < n_data) ? pay[i] : 8'h00);
    for (int b = 0; b < 32; b++) rev[b] = c[31-b];
    return ~rev;
  endfunction

  function automatic logic [31:0] cap_word(input int k);
    return {capb(k+3), capb(k+2), capb(k+1), capb(k)};
  endfunction

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic send(input int first, input int n, input bit with_last);
    int  i;
    int  guard;
    bit  r;
    i = 0; guard = 0;
    while (i < n && !abort && guard < 2000) begin
      drv_data  = pay[first+i];
      drv_last  = with_last && (i == n-1);
      drv_valid = 1'b1;
      @(negedge clk);
      r = m_rdy;
      @(posedge clk);
      #1;
      if (r) i++;
      guard++;
    end
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    check("send_done", 32'((i == n) || abort), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (m_busy !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(k < 400), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int e;
    logic [31:0] c, f;

    rst_n = 1'b0; giga_mode = 1'b1; sel = 1'b0; abort = 1'b0;
    drv_data = 8'h00; drv_valid = 1'b0; drv_last = 1'b0;
    mon_clr = 1'b1; mon_giga = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_tx_en", 32'(a_tx_en), 32'd0);
    check("rst_txd", 32'(a_txd), 32'd0);
    check("rst_s_ready", 32'(ifa.s_ready), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_frame_cnt", 32'(a_frame_cnt), 32'd0);
    check("rst_underrun_cnt", 32'(a_underrun_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    // T1: giga 64-byte frame 00..3F
    for (int i = 0; i < 64; i++) pay[i] = 8'(i);
    giga_mode = 1'b1; mon_giga = 1'b1;
    clear_mon();
    send(0, 64, 1'b1);
    wait_idle("t1_idle");
    check("t1_en_clks", 32'(en_clks), 32'd76);
    check("t1_len", 32'(cap.size()), 32'd76);
    e = 0;
    for (int k = 0; k < 7; k++) if (capb(k) !== 8'h55) e++;
    if (capb(7) !== 8'hD5) e++;
    check("t1_preamble_sfd_errs", 32'(e), 32'd0);
    e = 0;
    for (int i = 0; i < 64; i++) if (capb(8+i) !== pay[i]) e++;
    check("t1_payload_errs", 32'(e), 32'd0);
    check("t1_fcs", cap_word(72), fcs_model(64, 64));
    check("t1_tx_er_clks", 32'(er_clks), 32'd0);
    check("t1_frame_cnt", 32'(a_frame_cnt), 32'd1);

    // T2: nibble 14-byte frame padded to 60
    for (int i = 0; i < 14; i++) pay[i] = 8'hA0 + 8'(i);
    giga_mode = 1'b0; mon_giga = 1'b0;
    clear_mon();
    send(0, 14, 1'b1);
    wait_idle("t2_idle");
    check("t2_en_clks", 32'(en_clks), 32'd144);
    check("t2_len", 32'(cap.size()), 32'd72);
    e = 0;
    for (int i = 0; i < 14; i++) if (capb(8+i) !== pay[i]) e++;
    for (int i = 14; i < 60; i++) if (capb(8+i) !== 8'h00) e++;
    check("t2_data_pad_errs", 32'(e), 32'd0);
    check("t2_fcs", cap_word(68), fcs_model(14, 60));
    check("t2_ready_consecutive", 32'(rdy_viol), 32'd0);
    check("t2_high_nibble_nonzero", 32'(hi_viol), 32'd0);
    check("t2_frame_cnt", 32'(a_frame_cnt), 32'd2);

    // T3: two back-to-back giga frames
    for (int i = 0; i < 64; i++) pay[i] = 8'(i * 5);
    giga_mode = 1'b1; mon_giga = 1'b1;
    clear_mon();
    send(0, 64, 1'b1);
    send(0, 64, 1'b1);
    wait_idle("t3_idle");
    check("t3_gap_clks", 32'(last_gap), 32'd12);
    check("t3_en_clks", 32'(en_clks), 32'd152);
    check("t3_fcs_second", cap_word(76 + 72), fcs_model(64, 64));
    check("t3_frame_cnt", 32'(a_frame_cnt), 32'd4);

    // T4: underflow after byte 20, rest drained
    for (int i = 0; i < 64; i++) pay[i] = 8'(i);
    clear_mon();
    send(0, 20, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    send(20, 44, 1'b1);
    wait_idle("t4_idle");
    repeat (4) @(negedge clk);
    check("t4_en_clks", 32'(en_clks), 32'd29);
    check("t4_tx_er_clks", 32'(er_clks), 32'd1);
    check("t4_underrun_cnt", 32'(a_underrun_cnt), 32'd1);
    check("t4_frame_cnt", 32'(a_frame_cnt), 32'd4);
    check("t4_busy_after_drain", 32'(a_busy), 32'd0);

    // T5: async reset mid-DATA, then a clean frame
    clear_mon();
    fork
      send(0, 64, 1'b1);
      begin
        repeat (20) @(posedge clk);
        #1 check("t5_tx_en_before_rst", 32'(a_tx_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_tx_en", 32'(a_tx_en), 32'd0);
        check("t5_rst_txd", 32'(a_txd), 32'd0);
        check("t5_rst_s_ready", 32'(ifa.s_ready), 32'd0);
        abort = 1'b1;
      end
    join
    @(negedge clk) rst_n = 1'b1;
    abort = 1'b0;
    check("t5_frame_cnt_cleared", 32'(a_frame_cnt), 32'd0);
    check("t5_underrun_cnt_cleared", 32'(a_underrun_cnt), 32'd0);
    for (int i = 0; i < 64; i++) pay[i] = 8'hFF - 8'(i);
    clear_mon();
    send(0, 64, 1'b1);
    wait_idle("t5_idle");
    check("t5_en_clks", 32'(en_clks), 32'd76);
    check("t5_fcs", cap_word(72), fcs_model(64, 64));
    check("t5_frame_cnt", 32'(a_frame_cnt), 32'd1);

    // T6: pass-through DUT, frame carries its own FCS
    sel = 1'b1;
    for (int i = 0; i < 60; i++) pay[i] = 8'(i * 7 + 3);
    f = fcs_model(60, 60);
    pay[60] = f[7:0]; pay[61] = f[15:8]; pay[62] = f[23:16]; pay[63] = f[31:24];
    clear_mon();
    send(0, 64, 1'b1);
    wait_idle("t6_idle");
    check("t6_en_clks", 32'(en_clks), 32'd72);
    e = 0;
    for (int i = 0; i < 64; i++) if (capb(8+i) !== pay[i]) e++;
    check("t6_payload_errs", 32'(e), 32'd0);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 64; i++) c = crc_upd(c, capb(8+i));
    check("t6_rx_residue", c, 32'hC704DD7B);
    check("t6_frame_cnt", 32'(b_frame_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
